// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for one shared WIDTH-bit add/subtract datapath.
// Optional op_count output is enabled by defining ADDSUB_OPCOUNT_EN.
module addsub_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_mgate,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_mgate,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             busy
`ifdef ADDSUB_OPCOUNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    // Handshake: a request transfers in a cycle where reqN_valid and reqN_ready are both
    // high; a response transfers in a cycle where rsp_valid and rsp_ready are both high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mgate_q;
    logic             cin_q;
    logic             id_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;
    logic             rsp_ovf_q;

    logic             grant1;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_d;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    // Requester 1 wins when it is alone or when requester 0 was served last.
    assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
    assign req0_ready = (state_q == IDLE) && req0_valid && !grant1;
    assign req1_ready = (state_q == IDLE) && grant1;

    assign b_eff  = mgate_q ? ~b_q : b_q;
    assign full_d = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_q};
    assign sum_d  = full_d[WIDTH-1:0];
    assign cout_d = full_d[WIDTH];
    assign ovf_d  = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            mgate_q      <= 1'b0;
            cin_q        <= 1'b0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        a_q          <= grant1 ? req1_a     : req0_a;
                        b_q          <= grant1 ? req1_b     : req0_b;
                        mgate_q      <= grant1 ? req1_mgate : req0_mgate;
                        cin_q        <= grant1 ? req1_cin   : req0_cin;
                        id_q         <= grant1;
                        last_grant_q <= grant1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum_q   <= sum_d;
                    rsp_cout_q  <= cout_d;
                    rsp_ovf_q   <= ovf_d;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign busy      = (state_q != IDLE);

`ifdef ADDSUB_OPCOUNT_EN
    logic [15:0] op_count_q;

    // Counts delivered responses only; saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else if ((state_q == RESP) && rsp_ready && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: reset, add/subtract, round-robin, back-pressure,
// mid-operation reset and (with ADDSUB_OPCOUNT_EN) the saturating op counter.
module tb_addsub_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_mgate, req0_cin;
    logic             req1_valid, req1_ready, req1_mgate, req1_cin;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf, busy;
    logic [WIDTH-1:0] rsp_sum;
`ifdef ADDSUB_OPCOUNT_EN
    logic [15:0]      op_count;
`endif

    int tests_run = 0;
    int failed    = 0;

    // {valid, id, cout, ovf, sum}
    logic [WIDTH+3:0] rsp_vec;
    assign rsp_vec = {rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum};

    addsub_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_mgate(req0_mgate), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_mgate(req1_mgate), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
`ifdef ADDSUB_OPCOUNT_EN
        , .op_count(op_count)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_mgate = 0; req0_cin = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_mgate = 0; req1_cin = 0;
    endtask

    task automatic set_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic m, input logic c);
        if (id == 0) begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_mgate = m; req0_cin = c;
        end else begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_mgate = m; req1_cin = c;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_reqs();
        rsp_ready = 1;
        rst = 1;
        cyc();
        #1;
        tests_run++;
        if (rsp_vec !== 12'h000) begin
            failed++; $display("FAIL reset_rsp: got %h expected %h", rsp_vec, 12'h000);
        end
        tests_run++;
        if ({busy, req1_ready, req0_ready} !== 3'b000) begin
            failed++; $display("FAIL reset_busy_ready: got %b expected 000", {busy, req1_ready, req0_ready});
        end
        cyc();
        rst = 0;
    endtask

    task automatic test_single_add();
        set_req(0, 8'h3C, 8'h05, 0, 0);
        rsp_ready = 1;
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failed++; $display("FAIL add_accept: got %b expected 01", {req1_ready, req0_ready});
        end
        cyc();
        clear_reqs();
        req0_a = 8'hFF;
        #1;
        tests_run++;
        if ({rsp_valid, busy} !== 2'b01) begin
            failed++; $display("FAIL add_exec: got valid,busy=%b expected 01", {rsp_valid, busy});
        end
        cyc();
        #1;
        tests_run++;
        if (rsp_vec !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h41}) begin
            failed++; $display("FAIL add_result: got %h expected %h", rsp_vec, {4'b1000, 8'h41});
        end
        cyc();
        #1;
        tests_run++;
        if ({rsp_valid, busy} !== 2'b00) begin
            failed++; $display("FAIL add_idle: got valid,busy=%b expected 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_subtract();
        logic [WIDTH-1:0] va [3];
        logic [WIDTH-1:0] vb [3];
        logic             vm [3];
        logic [WIDTH+3:0] ve [3];
        va[0] = 8'h05; vb[0] = 8'h07; vm[0] = 1; ve[0] = {4'b1100, 8'hFE};
        va[1] = 8'h80; vb[1] = 8'h01; vm[1] = 1; ve[1] = {4'b1111, 8'h7F};
        va[2] = 8'h7F; vb[2] = 8'h01; vm[2] = 0; ve[2] = {4'b1101, 8'h80};
        rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            set_req(1, va[i], vb[i], vm[i], vm[i]);
            #1;
            tests_run++;
            if ({req1_ready, req0_ready} !== 2'b10) begin
                failed++; $display("FAIL sub_accept[%0d]: got %b expected 10", i, {req1_ready, req0_ready});
            end
            cyc();
            clear_reqs();
            cyc();
            #1;
            tests_run++;
            if (rsp_vec !== ve[i]) begin
                failed++; $display("FAIL sub_result[%0d]: got %h expected %h", i, rsp_vec, ve[i]);
            end
            cyc();
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy;
        do_reset();
        rsp_ready = 1;
        set_req(0, 8'h10, 8'h01, 0, 0);
        set_req(1, 8'h20, 8'h02, 1, 1);
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_rdy = (c % 6 == 0) ? 2'b01 : (c % 6 == 3) ? 2'b10 : 2'b00;
            tests_run++;
            if ({req1_ready, req0_ready} !== exp_rdy) begin
                failed++; $display("FAIL rr_grant[c%0d]: got %b expected %b", c, {req1_ready, req0_ready}, exp_rdy);
            end
            if (c % 6 == 2) begin
                tests_run++;
                if (rsp_vec !== {4'b1000, 8'h11}) begin
                    failed++; $display("FAIL rr_rsp0[c%0d]: got %h expected %h", c, rsp_vec, {4'b1000, 8'h11});
                end
            end else if (c % 6 == 5) begin
                tests_run++;
                if (rsp_vec !== {4'b1110, 8'h1E}) begin
                    failed++; $display("FAIL rr_rsp1[c%0d]: got %h expected %h", c, rsp_vec, {4'b1110, 8'h1E});
                end
            end else begin
                tests_run++;
                if (rsp_valid !== 1'b0) begin
                    failed++; $display("FAIL rr_novalid[c%0d]: got %b expected 0", c, rsp_valid);
                end
            end
            cyc();
        end
        clear_reqs();
    endtask

    task automatic test_back_pressure();
        rsp_ready = 0;
        set_req(0, 8'h01, 8'h01, 0, 0);
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failed++; $display("FAIL bp_accept: got %b expected 01", {req1_ready, req0_ready});
        end
        cyc();
        clear_reqs();
        set_req(1, 8'h90, 8'h90, 0, 0);
        cyc();
        for (int k = 0; k < 10; k++) begin
            #1;
            tests_run++;
            if ({rsp_vec, busy, req1_ready} !== {4'b1000, 8'h02, 2'b10}) begin
                failed++; $display("FAIL bp_stall[%0d]: got rsp=%h busy=%b rdy1=%b expected rsp=802 busy=1 rdy1=0",
                                   k, rsp_vec, busy, req1_ready);
            end
            cyc();
        end
        rsp_ready = 1;
        #1;
        tests_run++;
        if ({rsp_vec, req1_ready} !== {4'b1000, 8'h02, 1'b0}) begin
            failed++; $display("FAIL bp_release: got rsp=%h rdy1=%b expected rsp=802 rdy1=0", rsp_vec, req1_ready);
        end
        cyc();
        #1;
        tests_run++;
        if ({rsp_valid, busy, req1_ready} !== 3'b001) begin
            failed++; $display("FAIL bp_next_accept: got %b expected 001", {rsp_valid, busy, req1_ready});
        end
        cyc();
        clear_reqs();
        cyc();
        #1;
        tests_run++;
        if (rsp_vec !== {4'b1111, 8'h20}) begin
            failed++; $display("FAIL bp_req1_result: got %h expected %h", rsp_vec, {4'b1111, 8'h20});
        end
        cyc();
    endtask

    task automatic test_reset_mid_op();
        rsp_ready = 1;
        set_req(0, 8'h11, 8'h22, 0, 0);
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failed++; $display("FAIL mid_accept: got %b expected 01", {req1_ready, req0_ready});
        end
        cyc();
        clear_reqs();
        rst = 1;
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            failed++; $display("FAIL mid_exec_busy: got %b expected 1", busy);
        end
        cyc();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if ({rsp_vec, busy} !== 13'h0) begin
                failed++; $display("FAIL mid_aborted[%0d]: got rsp=%h busy=%b expected rsp=000 busy=0", k, rsp_vec, busy);
            end
            cyc();
        end
        set_req(0, 8'h44, 8'h04, 1, 1);
        set_req(1, 8'h55, 8'h05, 0, 0);
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failed++; $display("FAIL mid_first_tie: got %b expected 01", {req1_ready, req0_ready});
        end
        cyc();
        clear_reqs();
        cyc();
        #1;
        tests_run++;
        if (rsp_vec !== {4'b1010, 8'h40}) begin
            failed++; $display("FAIL mid_tie_result: got %h expected %h", rsp_vec, {4'b1010, 8'h40});
        end
        cyc();
    endtask

`ifdef ADDSUB_OPCOUNT_EN
    task automatic run_op0();
        set_req(0, 8'h01, 8'h01, 0, 0);
        cyc();
        clear_reqs();
        cyc();
        cyc();
    endtask

    task automatic test_opcount();
        rsp_ready = 1;
        do_reset();
        #1;
        tests_run++;
        if (op_count !== 16'd0) begin
            failed++; $display("FAIL opcount_reset: got %h expected 0000", op_count);
        end
        for (int i = 0; i < 5; i++) run_op0();
        #1;
        tests_run++;
        if (op_count !== 16'd5) begin
            failed++; $display("FAIL opcount_five: got %h expected 0005", op_count);
        end
        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        cyc();
        for (int i = 0; i < 2; i++) begin
            run_op0();
            #1;
            tests_run++;
            if (op_count !== 16'hFFFF) begin
                failed++; $display("FAIL opcount_sat[%0d]: got %h expected FFFF", i, op_count);
            end
        end
    endtask
`endif

    initial begin
        clear_reqs();
        rst = 1;
        rsp_ready = 1;
        cyc();
        test_reset();
        test_single_add();
        test_subtract();
        test_contention();
        test_back_pressure();
        test_reset_mid_op();
`ifdef ADDSUB_OPCOUNT_EN
        test_opcount();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one WIDTH-bit ripple add/subtract datapath between two requesters using round-robin arbitration.
- Each accepted request carries operands, mode (mgate) and carry-in.
- The block sequences a single operation at a time and returns one registered result tagged with the requester id.
- Sits between the requesting units and the shared adder datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand A, requester 0.
- req0_b  in  WIDTH  operand B, requester 0.
- req0_mgate  in  1  0 = add, 1 = subtract (B inverted), requester 0.
- req0_cin  in  1  carry-in, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_mgate, req1_cin: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester that owns the result.
- rsp_sum  out  WIDTH  result.
- rsp_cout  out  1  carry out of MSB.
- rsp_ovf  out  1  signed overflow.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state = IDLE; rsp_valid = 0; rsp_id = 0; rsp_sum = 0; rsp_cout = 0; rsp_ovf = 0; busy = 0; last_grant = 1, so requester 0 wins the first tie.
  - Reset in any state aborts the in-flight operation; its result is never presented.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If no reqN_valid is high, stay in IDLE.
  - Otherwise grant one requester, combinationally assert its reqN_ready (reqN_ready = grant and reqN_valid and state==IDLE), capture a, b, mgate, cin and the id, then go to EXEC.
  - Both ready outputs are 0 in every other state.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester that is not last_grant wins.
  - last_grant updates on acceptance.
- EXEC (exactly one cycle):
  - b_eff = mgate ? ~b : b.
  - full = a + b_eff + cin, computed at WIDTH+1 bits.
  - rsp_sum = full[WIDTH-1:0]; rsp_cout = full[WIDTH].
  - rsp_ovf = (a[MSB] == b_eff[MSB]) and (rsp_sum[MSB] != a[MSB]).
  - All result fields are registered; go to RESP.
- RESP:
  - rsp_valid = 1; all rsp_* fields are held stable until rsp_ready is sampled high.
  - On the cycle rsp_ready is high, go to IDLE; rsp_valid falls the next cycle.
  - No new request is accepted in the same cycle.
- Latency and throughput:
  - Acceptance in cycle N gives rsp_valid in cycle N+2.
  - Peak throughput is one operation per 3 cycles.
- A requester that drops valid before ready is high has no effect and leaves no state behind.
- Subtraction without wrap requires cin = 1 (two's complement); the block does not force cin.
- Back-pressure: holding rsp_ready low stalls indefinitely in RESP. Requests stay pending with ready low and the arbiter state is unchanged.
- Operand changes on reqN_* after acceptance do not affect the in-flight result.

Optional Feature:
- Macro: ADDSUB_OPCOUNT_EN.
- Defined: adds output op_count, 16 bits.
  - Increments on each RESP->IDLE transition (rsp_valid and rsp_ready).
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single add: req0 a=8'h3C, b=8'h05, mgate=0, cin=0, rsp_ready=1 -> ready pulse in cycle N; rsp_valid in cycle N+2 with sum=8'h41, cout=0, ovf=0, id=0.
- Subtract: req1 a=8'h05, b=8'h07, mgate=1, cin=1 -> sum=8'hFE, cout=0, ovf=0, id=1. Same with a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Contention: both valid continuously after reset, rsp_ready=1 -> grants in order 0,1,0,1; each grant is 3 cycles apart; ids match.
- Back-pressure: rsp_ready=0 for 10 cycles with a result pending and req1 valid -> rsp_* stable, busy=1, req1_ready=0 throughout. Raise rsp_ready -> IDLE, then req1 is accepted the next cycle.
- Reset mid-op: assert rst during EXEC -> next cycle state IDLE, rsp_valid=0, busy=0; no response for the aborted op. First tie after reset goes to requester 0.
- With ADDSUB_OPCOUNT_EN: 5 completed ops -> op_count=5. Preload near max (force) -> holds at 16'hFFFF.
